// File: rtl/operacao_pkg.sv
// Shared types and widths for the quadratic evaluator operacao.
package operacao_pkg;

  localparam int XW = 8;
  localparam int DW = 16;

  // Controller states, in the order a computation walks through them.
  typedef enum logic [2:0] {
    IDLE,
    SQ,
    MA,
    MB,
    SUM,
    DONE
  } state_e;

  // Operand pairs fed to the single shared multiplier.
  typedef enum logic [1:0] {
    MUL_XX,
    MUL_AT,
    MUL_BX
  } mul_sel_e;

  // Zero-extends the polynomial variable to datapath width.
  function automatic logic [DW-1:0] zext_x(input logic [XW-1:0] x);
    return {{(DW - XW){1'b0}}, x};
  endfunction

endpackage

// File: rtl/operacao_if.sv
// Start/ready handshake and operand bus of operacao.
interface operacao_if;
  import operacao_pkg::*;

  logic          inicio;
  logic [XW-1:0] X;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [DW-1:0] C;
  logic [DW-1:0] resultado;
  logic          pronto;
  logic          comecou;

  modport master (
    output inicio, X, A, B, C,
    input  resultado, pronto, comecou
  );

  modport slave (
    input  inicio, X, A, B, C,
    output resultado, pronto, comecou
  );

endinterface

// File: rtl/operacao_datapath.sv
// Operand registers, shared 16x16->16 multiplier, three-input adder and
// result register; sequenced by enables from the operacao controller.
module operacao_datapath
  import operacao_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic          t_en,
  input  logic          acc_en,
  input  logic          res_en,
  input  mul_sel_e      mul_sel,
  input  logic [XW-1:0] x_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [DW-1:0] c_in,
  output logic [DW-1:0] resultado
);

  logic [XW-1:0] xr_q, xr_d;
  logic [DW-1:0] ar_q, ar_d;
  logic [DW-1:0] br_q, br_d;
  logic [DW-1:0] cr_q, cr_d;
  logic [DW-1:0] t_q, t_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] res_q, res_d;

  logic [DW-1:0] x_ext;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [DW-1:0] product;
  logic [DW-1:0] sum;

  // Steer the shared multiplier and form the truncated product and sum.
  always_comb begin
    x_ext = zext_x(xr_q);
    mul_a = x_ext;
    mul_b = x_ext;
    case (mul_sel)
      MUL_XX: begin
        mul_a = x_ext;
        mul_b = x_ext;
      end
      MUL_AT: begin
        mul_a = ar_q;
        mul_b = t_q;
      end
      MUL_BX: begin
        mul_a = br_q;
        mul_b = x_ext;
      end
      default: begin
        mul_a = x_ext;
        mul_b = x_ext;
      end
    endcase
    product = mul_a * mul_b;
    sum     = acc_q + t_q + cr_q;
  end

  // Next-state of every register; each holds unless its enable is set.
  always_comb begin
    xr_d  = xr_q;
    ar_d  = ar_q;
    br_d  = br_q;
    cr_d  = cr_q;
    t_d   = t_q;
    acc_d = acc_q;
    res_d = res_q;
    if (load_en) begin
      xr_d = x_in;
      ar_d = a_in;
      br_d = b_in;
      cr_d = c_in;
    end
    if (t_en) begin
      t_d = product;
    end
    if (acc_en) begin
      acc_d = product;
    end
    if (res_en) begin
      res_d = sum;
    end
  end

  // Register bank; an asserted reset discards any partial computation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xr_q  <= '0;
      ar_q  <= '0;
      br_q  <= '0;
      cr_q  <= '0;
      t_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      xr_q  <= xr_d;
      ar_q  <= ar_d;
      br_q  <= br_d;
      cr_q  <= cr_d;
      t_q   <= t_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign resultado = res_q;

endmodule

// File: rtl/operacao.sv
// Sequential evaluator of A*X^2 + B*X + C (mod 2^16) behind a start/ready
// handshake; the controller here drives operacao_datapath.
module operacao
  import operacao_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  operacao_if.slave bus
);

  state_e   state_q, state_d;
  logic     comecou_q, comecou_d;
  logic     pronto_q, pronto_d;
  logic     load_en;
  logic     t_en;
  logic     acc_en;
  logic     res_en;
  mul_sel_e mul_sel;

  // Next state and datapath control; DONE is left only after pronto has
  // been shown and inicio is low, so a held inicio never retriggers.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    t_en    = 1'b0;
    acc_en  = 1'b0;
    res_en  = 1'b0;
    mul_sel = MUL_XX;
    case (state_q)
      IDLE: begin
        if (bus.inicio) begin
          load_en = 1'b1;
          state_d = SQ;
        end
      end
      SQ: begin
        mul_sel = MUL_XX;
        t_en    = 1'b1;
        state_d = MA;
      end
      MA: begin
        mul_sel = MUL_AT;
        acc_en  = 1'b1;
        state_d = MB;
      end
      MB: begin
        mul_sel = MUL_BX;
        t_en    = 1'b1;
        state_d = SUM;
      end
      SUM: begin
        res_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!bus.inicio && pronto_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs go through their own register stage: busy rises on
  // the start edge and drops exactly when pronto rises, so they never overlap.
  always_comb begin
    comecou_d = (state_q == IDLE && bus.inicio) ||
                (state_q == SQ) || (state_q == MA) ||
                (state_q == MB) || (state_q == SUM);
    pronto_d  = (state_q == DONE) && (state_d == DONE);
  end

  // State and handshake registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      comecou_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      comecou_q <= comecou_d;
      pronto_q  <= pronto_d;
    end
  end

  operacao_datapath u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .t_en      (t_en),
    .acc_en    (acc_en),
    .res_en    (res_en),
    .mul_sel   (mul_sel),
    .x_in      (bus.X),
    .a_in      (bus.A),
    .b_in      (bus.B),
    .c_in      (bus.C),
    .resultado (bus.resultado)
  );

  assign bus.comecou = comecou_q;
  assign bus.pronto  = pronto_q;

endmodule

// File: tb/tb_operacao.sv
// Directed self-checking bench for operacao.
module tb_operacao;
  import operacao_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  operacao_if bus ();

  operacao dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariant watch: busy and done never overlap, and resultado only moves
  // on the fifth busy sample (the SUM->DONE edge) or while reset is low.
  logic [DW-1:0] prev_res;
  int            busy_run;

  initial begin
    total    = 0;
    bad      = 0;
    prev_res = '0;
    busy_run = 0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev_res = bus.resultado;
      busy_run = 0;
    end else begin
      if (bus.comecou === 1'b1) busy_run = busy_run + 1;
      else busy_run = 0;
      total = total + 1;
      if (bus.pronto === 1'b1 && bus.comecou === 1'b1) begin
        bad = bad + 1;
        $display("[TB] FAIL overlap at %0t: pronto=%b comecou=%b, want not both 1",
                 $time, bus.pronto, bus.comecou);
      end
      total = total + 1;
      if (bus.resultado !== prev_res && busy_run != 5) begin
        bad = bad + 1;
        $display("[TB] FAIL res_stable at %0t: resultado %0d -> %0d, want unchanged outside SUM->DONE",
                 $time, prev_res, bus.resultado);
      end
      prev_res = bus.resultado;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [XW-1:0] x, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW-1:0] c);
    bus.X      = x;
    bus.A      = a;
    bus.B      = b;
    bus.C      = c;
    bus.inicio = 1'b1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if (bus.resultado !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_res: got %0d want 0", bus.resultado);
    end
    total++;
    if (bus.pronto !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_pronto: got %b want 0", bus.pronto);
    end
    total++;
    if (bus.comecou !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_comecou: got %b want 0", bus.comecou);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    applyStimulus(8'd2, 16'd1, 16'd2, 16'd5);
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (bus.comecou !== 1'b1 || bus.pronto !== 1'b0) begin
        bad++;
        $display("[TB] FAIL basic_busy cycle %0d: comecou=%b pronto=%b want comecou=1 pronto=0",
                 i, bus.comecou, bus.pronto);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      else step();
      total++;
      if (bus.pronto !== 1'b1 || bus.comecou !== 1'b0 || bus.resultado !== 16'd13) begin
        bad++;
        $display("[TB] FAIL basic_done hold %0d: pronto=%b comecou=%b res=%0d want 1 0 13",
                 i, bus.pronto, bus.comecou, bus.resultado);
      end
    end
    bus.inicio = 1'b0;
    step();
    total++;
    if (bus.pronto !== 1'b0 || bus.comecou !== 1'b0 || bus.resultado !== 16'd13) begin
      bad++;
      $display("[TB] FAIL basic_idle: pronto=%b comecou=%b res=%0d want 0 0 13",
               bus.pronto, bus.comecou, bus.resultado);
    end
  endtask

  task automatic test_latency();
    int n;
    applyStimulus(8'd10, 16'd3, 16'd4, 16'd7);
    step();
    bus.X = 8'd99;
    bus.A = 16'd1000;
    bus.B = 16'd77;
    bus.C = 16'd5;
    n = 0;
    while (bus.pronto !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 5) begin
      bad++;
      $display("[TB] FAIL latency_cycles: got %0d want 5", n);
    end
    total++;
    if (bus.resultado !== 16'd347) begin
      bad++;
      $display("[TB] FAIL latency_res: got %0d want 347", bus.resultado);
    end
    bus.inicio = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    int n;
    applyStimulus(8'd255, 16'd2, 16'd0, 16'd0);
    n = 0;
    while (bus.pronto !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.pronto !== 1'b1 || bus.resultado !== 16'd64514) begin
      bad++;
      $display("[TB] FAIL wrap_255: pronto=%b res=%0d want 1 64514", bus.pronto, bus.resultado);
    end
    bus.inicio = 1'b0;
    step();
    applyStimulus(8'd0, 16'hFFFF, 16'hFFFF, 16'd9);
    n = 0;
    while (bus.pronto !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.pronto !== 1'b1 || bus.resultado !== 16'd9) begin
      bad++;
      $display("[TB] FAIL wrap_x0: pronto=%b res=%0d want 1 9", bus.pronto, bus.resultado);
    end
    bus.inicio = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    applyStimulus(8'd2, 16'd2, 16'd2, 16'd2);
    n = 0;
    while (bus.pronto !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.pronto !== 1'b1 || bus.resultado !== 16'd14) begin
      bad++;
      $display("[TB] FAIL b2b_first: pronto=%b res=%0d want 1 14", bus.pronto, bus.resultado);
    end
    bus.inicio = 1'b0;
    step();
    total++;
    if (bus.pronto !== 1'b0 || bus.comecou !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_idle: pronto=%b comecou=%b want 0 0", bus.pronto, bus.comecou);
    end
    applyStimulus(8'd1, 16'd1, 16'd1, 16'd1);
    step();
    total++;
    if (bus.comecou !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_restart: comecou=%b want 1", bus.comecou);
    end
    n = 0;
    while (bus.pronto !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 5 || bus.resultado !== 16'd3) begin
      bad++;
      $display("[TB] FAIL b2b_second: cycles=%0d res=%0d want 5 3", n, bus.resultado);
    end
    bus.inicio = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    applyStimulus(8'd10, 16'd3, 16'd4, 16'd7);
    step();
    step();
    total++;
    if (bus.comecou !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_busy: comecou=%b want 1", bus.comecou);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.resultado !== 16'd0 || bus.pronto !== 1'b0 || bus.comecou !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_async: res=%0d pronto=%b comecou=%b want 0 0 0",
               bus.resultado, bus.pronto, bus.comecou);
    end
    bus.inicio = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.resultado !== 16'd0 || bus.pronto !== 1'b0 || bus.comecou !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midrst_idle cycle %0d: res=%0d pronto=%b comecou=%b want 0 0 0",
                 i, bus.resultado, bus.pronto, bus.comecou);
      end
    end
  endtask

  initial begin
    bus.inicio = 1'b0;
    bus.X      = '0;
    bus.A      = '0;
    bus.B      = '0;
    bus.C      = '0;
    reset      = 1'b1;
    #2;
    reset      = 1'b0;
    $display("[TB] starting operacao tests");
    test_reset();
    test_basic();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operacao.md
Name: operacao

Overview:
- Sequential evaluator of the quadratic polynomial resultado = A·X² + B·X + C.
- Unsigned arithmetic, modulo 2^16.
- A start/ready handshake with a small FSM drives a datapath containing one shared multiplier and one adder.
- Used as a standalone arithmetic unit started by a controller that raises inicio and waits for pronto.

Parameters:
- XW, 8, width of operand X.
- DW, 16, width of A, B, C and resultado.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- inicio  input  1  start request, level-sensitive, sampled on clk rising edge.
- X  input  8  polynomial variable, unsigned.
- A  input  16  quadratic coefficient, unsigned.
- B  input  16  linear coefficient, unsigned.
- C  input  16  constant term, unsigned.
- resultado  output  16  A·X²+B·X+C mod 2^16, registered.
- pronto  output  1  result valid / operation complete.
- comecou  output  1  operation in progress (busy).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Operand registers, temp register and accumulator go to 0.
  - resultado=0, pronto=0, comecou=0.
  - Reset mid-operation aborts the computation. No partial result is kept.
- Arithmetic:
  - X is zero-extended to 16 bits.
  - Every product and sum is truncated to the low 16 bits (mod 2^16).
  - No overflow flag.
- FSM states: IDLE, SQ, MA, MB, SUM, DONE.
- IDLE:
  - comecou=0, pronto=0, resultado holds its last value.
  - If inicio=1 at an edge: latch X, A, B, C into internal registers and go to SQ.
  - Input changes after this latch do not affect the result.
- SQ: t <= Xr·Xr, go to MA. comecou=1.
- MA: acc <= Ar·t, go to MB. comecou=1.
- MB: t <= Br·Xr, go to SUM. comecou=1.
- SUM: resultado <= acc + t + Cr, go to DONE. comecou=1.
- DONE:
  - pronto=1, comecou=0, resultado stable.
  - Stay in DONE while inicio=1, so a held-high inicio does not retrigger.
  - Go to IDLE when inicio=0.
- Latency: inicio sampled at edge k; comecou is high from edge k through edge k+4; pronto and valid resultado are asserted from edge k+5.
- Outputs are registered, or decoded from the registered state only; no combinational path from inputs to outputs.
- comecou and pronto are never high simultaneously.
- inicio toggling during SQ..SUM is ignored.
- A new start is possible one cycle after leaving DONE, i.e. after inicio is seen low.

Decomposition:
- Shared package operacao_pkg:
  - State enum (IDLE, SQ, MA, MB, SUM, DONE).
  - Width constants XW=8, DW=16.
- One natural sub-module, operacao_datapath:
  - Holds the operand registers, t, acc and resultado.
  - Contains the single 16x16→16 truncating multiplier with operand muxes, plus the three-input adder.
  - Controlled by select/enable signals from the FSM in the top-level operacao.

Test Plan:
- Reset low, then release and hold inicio=1 with X=2, A=1, B=2, C=5 -> comecou high for 5 cycles, then pronto=1 with resultado=13, held while inicio stays 1.
- X=10, A=3, B=4, C=7 -> resultado=347. Pronto exactly 5 cycles after the start edge. Inputs changed the cycle after start do not alter the result.
- X=255, A=2, B=0, C=0 -> resultado=64514 (130050 mod 65536), checking wrap-around. X=0, A=B=0xFFFF, C=9 -> resultado=9.
- Back-to-back runs:
  - After pronto, drop inicio -> IDLE, pronto=0.
  - Restart with X=1, A=B=C=1 -> resultado=3.
- Assert reset=0 during MA -> all outputs 0 immediately (asynchronous). After release with inicio=0 the FSM stays in IDLE.
- Throughout all runs: assertions that pronto and comecou are never both 1, and that resultado only changes on the SUM->DONE edge or reset.
